// File: rtl/pc_sequencer_pkg.sv
// Shared defaults, state encoding and small helpers for the PC sequencer.
package pc_sequencer_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Word-aligned fetch: any nonzero low two bits traps.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// Plain modular adder used for the sequential pc+4 increment.
module pc_sequencer_adder #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic [OPERAND_WIDTH-1:0] a,
  input  logic [OPERAND_WIDTH-1:0] b,
  output logic [OPERAND_WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT control with redirect, stall, trap on
// misaligned redirect, and a wrapping count of consumed fetches.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int             XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  state_t          state;
  logic [XLEN-1:0] pc_inc;
  logic            trap;

  pc_sequencer_adder #(.OPERAND_WIDTH(XLEN)) u_pc_add (
    .a  (pc),
    .b  (XLEN'(4)),
    .sum(pc_inc)
  );

  assign trap = redirect_valid && is_misaligned(redirect_target[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      pc_valid    <= 1'b0;
      misalign    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      misalign <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          // pc already holds RESET_VECTOR; just make it live.
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (trap) begin
            pc       <= TRAP_VECTOR;
            misalign <= 1'b1;
          end else if (redirect_valid) begin
            pc <= redirect_target;
          end else if (!stall) begin
            pc <= pc_inc;
          end
          // A redirect under stall moves the pc but is not a consumed fetch.
          if (!stall) fetch_count <= fetch_count + XLEN'(1);
          if (halt_req) begin
            state    <= ST_HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume && !halt_req) begin
            state    <= ST_RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic        misalign;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .misalign       (misalign),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_vld,
                         input logic e_mis, input logic e_hlt, input logic [31:0] e_fc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(e_vld));
    chk({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
    chk({tag, ".halted"}, 32'(halted), 32'(e_hlt));
    chk({tag, ".fetch_count"}, fetch_count, e_fc);
  endtask

  // Advance one rising edge and settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rt,
                       input logic h, input logic r);
    stall = s; redirect_valid = rv; redirect_target = rt; halt_req = h; resume = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    step();
    chk_all("reset", 32'h0, 0, 0, 0, 32'd0);

    rst = 1'b0;
    chk_all("boot_c1", 32'h0, 0, 0, 0, 32'd0);
    step();
    chk_all("boot_c2", 32'h0, 1, 0, 0, 32'd0);
    step();
    chk_all("run_c3", 32'h4, 1, 0, 0, 32'd1);
    step();
    chk_all("run_pc8", 32'h8, 1, 0, 0, 32'd2);

    drive(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall_hold", 32'h8, 1, 0, 0, 32'd2);
    end

    drive(1, 1, 32'h40, 0, 0);
    step();
    chk_all("redir_over_stall", 32'h40, 1, 0, 0, 32'd2);

    drive(0, 1, 32'h43, 0, 0);
    step();
    chk_all("trap", 32'h100, 1, 1, 0, 32'd3);

    drive(0, 0, 32'h0, 0, 0);
    step();
    chk_all("trap_pulse_end", 32'h104, 1, 0, 0, 32'd4);

    drive(1, 1, 32'h202, 0, 0);
    step();
    chk_all("trap_under_stall", 32'h100, 1, 1, 0, 32'd4);

    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    step();
    chk_all("to_top", 32'hFFFF_FFFC, 1, 0, 0, 32'd5);

    drive(0, 0, 32'h0, 0, 0);
    step();
    chk_all("wrap", 32'h0, 1, 0, 0, 32'd6);

    drive(0, 1, 32'h20, 0, 0);
    step();
    chk_all("to_20", 32'h20, 1, 0, 0, 32'd7);

    drive(0, 0, 32'h0, 1, 0);
    step();
    chk_all("halt_enter", 32'h24, 0, 0, 1, 32'd8);

    drive(0, 1, 32'h80, 0, 0);
    step();
    chk_all("halt_ign_redir", 32'h24, 0, 0, 1, 32'd8);

    drive(1, 1, 32'h83, 0, 0);
    step();
    chk_all("halt_ign_trap", 32'h24, 0, 0, 1, 32'd8);

    drive(0, 0, 32'h0, 1, 1);
    step();
    chk_all("halt_both", 32'h24, 0, 0, 1, 32'd8);

    drive(0, 0, 32'h0, 0, 1);
    step();
    chk_all("resume", 32'h24, 1, 0, 0, 32'd8);

    drive(0, 0, 32'h0, 0, 0);
    step();
    chk_all("after_resume", 32'h28, 1, 0, 0, 32'd9);

    drive(0, 0, 32'h0, 1, 0);
    step();
    chk_all("halt_again", 32'h2C, 0, 0, 1, 32'd10);

    // Asynchronous reset mid-cycle while halted with a redirect pending.
    drive(0, 1, 32'h80, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 0, 0, 0, 32'd0);
    step();
    chk_all("rst_held", 32'h0, 0, 0, 0, 32'd0);

    // halt_req/resume high during BOOT must be ignored.
    rst = 1'b0;
    step();
    chk_all("reboot_run", 32'h0, 1, 0, 0, 32'd0);
    drive(0, 0, 32'h0, 0, 0);
    step();
    chk_all("reboot_inc", 32'h4, 1, 0, 0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC target on a misaligned redirect.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold the current PC (downstream not ready).
REQ-007 redirect_valid  input  1  jump/branch taken this cycle.
REQ-008 redirect_target  input  XLEN  jump/branch destination.
REQ-009 halt_req  input  1  request entry to HALT.
REQ-010 resume  input  1  leave HALT.
REQ-011 pc  output  XLEN  current fetch address (registered).
REQ-012 pc_valid  output  1  pc is a live fetch address this cycle.
REQ-013 misalign  output  1  one-cycle pulse: misaligned redirect was trapped.
REQ-014 halted  output  1  high while in HALT.
REQ-015 fetch_count  output  XLEN  count of consumed fetches.

Function
REQ-016 States SHALL be BOOT, RUN and HALT, with all outputs registered.
REQ-017 BOOT SHALL last exactly one cycle after reset release, with pc=RESET_VECTOR and pc_valid=0, then go to RUN with pc unchanged, so the instruction at RESET_VECTOR is presented only after reset.
REQ-018 In RUN, pc_valid SHALL be 1 and the next pc SHALL follow this priority:
- misaligned redirect (redirect_valid=1, redirect_target[1:0]!=0) -> TRAP_VECTOR, misalign=1 on the next cycle;
- aligned redirect -> redirect_target;
- stall -> pc held;
- otherwise -> pc+4.
REQ-019 A redirect SHALL override a simultaneous stall.
REQ-020 pc+4 SHALL wrap modulo 2^XLEN: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 fetch_count SHALL increment by 1 on every RUN cycle with stall=0, including redirect cycles, and SHALL wrap modulo 2^XLEN.
REQ-022 halt_req in RUN SHALL apply that cycle's pc update, then enter HALT on the same edge.
REQ-023 In HALT:
- pc_valid=0 and halted=1;
- pc and fetch_count held;
- redirect_valid and stall ignored.
REQ-024 resume in HALT SHALL return to RUN with pc unchanged; halt_req and resume both high in HALT SHALL keep the block in HALT.
REQ-025 halt_req and resume SHALL be ignored in BOOT.
REQ-026 misalign SHALL be 0 in every cycle not immediately following a trapped redirect.

Reset
REQ-027 rst=1 SHALL, asynchronously, set state=BOOT, pc=RESET_VECTOR, pc_valid=0, misalign=0, halted=0, fetch_count=0.
REQ-028 Assertion of rst mid-operation, in any state, SHALL abandon any pending redirect, halt or trap.
REQ-029 After rst deasserts, the block SHALL restart at REQ-017.

Structure
REQ-030 XLEN, RESET_VECTOR, TRAP_VECTOR defaults and the 2-bit state encodings (BOOT=0, RUN=1, HALT=2) SHALL live in the shared Parameters.vh include.
REQ-031 The block SHALL instantiate the existing Adder (OPERAND_WIDTH=XLEN) as its one sub-module for pc+4; all other logic SHALL be local to the block.

Verification
REQ-032 Reset, then release rst -> cycle 1: pc=0, pc_valid=0; cycle 2: pc=0, pc_valid=1; cycle 3: pc=4.
REQ-033 In RUN at pc=8: stall=1 for 3 cycles -> pc stays 8 and fetch_count is unchanged; then redirect_valid=1 with target 32'h40 and stall=1 -> next pc=32'h40.
REQ-034 redirect_target=32'h43 -> next pc=32'h100 and misalign=1 for exactly one cycle.
REQ-035 Force pc to 32'hFFFF_FFFC, no stall -> next pc=0 and fetch_count increments.
REQ-036 halt_req at pc=32'h20 -> pc=32'h24, halted=1, pc_valid=0; redirect to 32'h80 during HALT is ignored; resume -> pc_valid=1 with pc=32'h24.
REQ-037 Assert rst while in HALT with fetch_count=5 -> immediately pc=0, fetch_count=0, halted=0, followed by the BOOT sequence.
